// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: result-select and ALU codes plus default datapath widths.
package riscv_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SUB = 3'b110
  } alu_ctrl_e;

  // A load is the only producer whose result is not ready for forwarding out of execute.
  function automatic logic is_load(input logic [1:0] result_src);
    return result_src == RES_MEM;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detection and redirect handling for the ID/EX boundary.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ValidE,
  input  logic [1:0]        ResultSrcE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              bubble_o
);

  logic lu;

  // Both source fields are compared for every opcode; x0 never creates a dependency.
  assign lu = ValidE & is_load(ResultSrcE) & (RdE != '0) &
              ((RdE == Rs1D) | (RdE == Rs2D));

  // A redirect wins over a load-use stall: the dependent instruction is wrong-path anyway.
  assign StallF   = lu & ~PCSrcE;
  assign StallD   = lu & ~PCSrcE;
  assign FlushD   = PCSrcE;
  assign bubble_o = lu | PCSrcE;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubbling and redirect squashing.
// Define HAZARD_STATS_EN to add saturating stall/flush counters (CNT_W wide).
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
`ifdef HAZARD_STATS_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              ALUSrcD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              JalrD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              JalrE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              ValidE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD
`ifdef HAZARD_STATS_EN
  ,output logic [CNT_W-1:0] stall_cnt
  ,output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int EW = 1 + 6 + 2 + 3 + 5 * XLEN + 3 * REG_AW;

  logic          bubble;
  logic [EW-1:0] ex_d;
  logic [EW-1:0] ex_q;

  hazard_unit #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .ValidE    (ValidE),
    .ResultSrcE(ResultSrcE),
    .RdE       (RdE),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .PCSrcE    (PCSrcE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .bubble_o  (bubble)
  );

  // A bubble is an all-zero word, so ValidE and every control bit drop together.
  assign ex_d = bubble ? '0 :
                {1'b1, RegWriteD, MemWriteD, ALUSrcD, JumpD, BranchD, JalrD,
                 ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
                 Rs1D, Rs2D, RdD};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign {ValidE, RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE,
          ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
          Rs1E, Rs2E, RdE} = ex_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Counters stick at all-ones instead of wrapping so long runs still read as "many".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (PCSrcE && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
